mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//   Multi-cycle control FSM for the MIPS core. Sequences the shared datapath (PC, IR, GRF,
//   ALU, DM) through FETCH/DECODE/EXEC/MEM/WB, one instruction at a time.
//   Decodes opcode/funct from the IR and drives all datapath write enables and mux selects.
//   Handshakes with data memory via mem_ready and counts retired instructions.
// PARAMETERS
//   CNT_W      32  width of retired-instruction counter instr_cnt
//   IMEM_WAIT  0   extra stall cycles spent in FETCH before IR/PC update (0..15)
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high
//   opcode     in   6      IR[31:26], valid from DECODE onward
//   funct      in   6      IR[5:0]
//   zero       in   1      ALU zero flag (valid in EXEC)
//   mem_ready  in   1      DM access complete; sampled only in MEM
//   pc_we      out  1      PC write enable
//   pc_sel     out  2      0 PC+4, 1 branch target, 2 jal target, 3 GPR[rs] (jr)
//   ir_we      out  1      IR write enable
//   reg_we     out  1      GRF write enable
//   reg_dst    out  2      0 rt, 1 rd, 2 $31
//   wd_sel     out  2      0 ALU, 1 DM data, 2 PC+4, 3 imm<<16 (lui)
//   alu_src    out  1      0 rt, 1 extended imm
//   ext_op     out  1      0 zero-extend, 1 sign-extend
//   alu_op     out  2      0 add, 1 sub, 2 or
//   mem_re     out  1      DM read request
//   mem_we     out  1      DM write request
//   retire     out  1      1-cycle pulse when an instruction completes
//   illegal    out  1      1-cycle pulse in DECODE for an unrecognised instruction
//   state      out  3      0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB
//   instr_cnt  out  CNT_W  retired count, wraps at 2^CNT_W
// BEHAVIOUR
//   - Reset (async): state=FETCH, wait counter=0, class reg=NOP, instr_cnt=0. While reset is high
//     every enable/pulse (pc_we, ir_we, reg_we, mem_re, mem_we, retire, illegal) is 0.
//   - Outputs are combinational from state + latched class. Any select not listed below is 0.
//   - Decoded classes:
//     R(op 0): addu f=100001, subu f=100011, jr f=001000, nop f=000000.
//     ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, jal 000011.
//     Anything else is ILLEGAL.
//   - FETCH: stay IMEM_WAIT cycles. On the last cycle ir_we=1, pc_we=1, pc_sel=0; go to DECODE.
//   - DECODE: latch class.
//     nop/ILLEGAL: retire=1, go to FETCH (ILLEGAL also pulses illegal).
//     jal: reg_we=1, reg_dst=2, wd_sel=2, pc_we=1, pc_sel=2, retire, go to FETCH.
//     jr: pc_we=1, pc_sel=3, retire, go to FETCH.
//     All other classes go to EXEC.
//   - EXEC: drives the same ALU controls as WB for each class.
//     addu: alu_op=0. subu: alu_op=1. ori: alu_src=1, ext_op=0, alu_op=2.
//     lui: alu_src=1. These four go to WB.
//     lw/sw: alu_src=1, ext_op=1, alu_op=0; go to MEM.
//     beq: alu_op=1, ext_op=1, pc_sel=1, pc_we=zero, retire, go to FETCH.
//   - MEM: holds the EXEC controls. mem_re (lw) or mem_we (sw) stays high until mem_ready=1.
//     On ready: sw retires and goes to FETCH; lw goes to WB. No timeout; waits indefinitely.
//   - WB: holds the EXEC controls, reg_we=1, retire, go to FETCH.
//     addu/subu: reg_dst=1, wd_sel=0. ori: reg_dst=0, wd_sel=0.
//     lui: reg_dst=0, wd_sel=3. lw: reg_dst=0, wd_sel=1.
//   - Latency (IMEM_WAIT=0): nop/jal/jr 2 cycles, beq 3, addu/subu/ori/lui 4,
//     sw 4+w, lw 5+w (w = extra MEM wait cycles).
//   - instr_cnt increments on every retire cycle, including ILLEGAL and a not-taken beq.
//     It wraps all-ones to 0.
//   - Exactly one of pc_we-with-retire or none per instruction. pc_we never occurs in MEM/WB.
//     mem_re and mem_we are never high together.
//   - reset asserted mid-instruction: immediate return to FETCH with enables low.
//     The aborted instruction is not counted.
//   - Illegal state encodings (5-7) go to FETCH on the next edge with all enables 0.
// TESTING
//   1 Reset mid-MEM of sw (mem_we=1) -> mem_we drops to 0 immediately, state=0, instr_cnt=0.
//   2 addu (op 0, f 100001) -> states 0,1,2,4. WB: reg_we=1, reg_dst=1, wd_sel=0.
//     retire in cycle 4, instr_cnt 0->1.
//   3 lw with mem_ready low for 3 MEM cycles -> mem_re held 4 cycles, then WB with wd_sel=1,
//     reg_dst=0. Total 8 cycles.
//   4 beq zero=1 -> EXEC pc_we=1, pc_sel=1. With zero=0 -> pc_we=0, retire=1.
//     Both take 3 cycles.
//   5 jal then jr -> DECODE: reg_dst=2, wd_sel=2, pc_sel=2; then pc_sel=3, reg_we=0.
//     Each takes 2 cycles.
//   6 opcode 111111 -> illegal=1 in DECODE, counted. Also IMEM_WAIT=2: FETCH lasts 3 cycles,
//     ir_we only in the last.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and the datapath.
// master = controller, slave = datapath side.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             ir_we;
    logic             reg_we;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic             alu_src;
    logic             ext_op;
    logic [1:0]       alu_op;
    logic             mem_re;
    logic             mem_we;
    logic             retire;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_we, pc_sel, ir_we, reg_we, reg_dst, wd_sel,
        output alu_src, ext_op, alu_op, mem_re, mem_we,
        output retire, illegal, state, instr_cnt
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_we, pc_sel, ir_we, reg_we, reg_dst, wd_sel,
        input  alu_src, ext_op, alu_op, mem_re, mem_we,
        input  retire, illegal, state, instr_cnt
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath enables/selects, DM handshake and retired-instruction count.
module mips_multicycle_ctrl #(
    parameter int CNT_W     = 32,
    parameter int IMEM_WAIT = 0
) (
    input logic clk,
    input logic reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LW,
        C_SW, C_BEQ, C_LUI, C_JAL, C_ILL
    } cls_t;

    state_t           st, st_nxt;
    cls_t             cls, dec_cls;
    logic [3:0]       wcnt;
    logic             fetch_done;
    logic [CNT_W-1:0] cnt;
    logic             pc_we, ir_we, reg_we, mem_re, mem_we;
    logic             retire, illegal, alu_src, ext_op;
    logic [1:0]       pc_sel, reg_dst, wd_sel, alu_op;

    assign fetch_done = (wcnt == 4'(IMEM_WAIT));

    always_comb begin
        dec_cls = C_ILL;
        unique case (1'b1)
            bus.opcode == 6'b000000 && bus.funct == 6'b100001: dec_cls = C_ADDU;
            bus.opcode == 6'b000000 && bus.funct == 6'b100011: dec_cls = C_SUBU;
            bus.opcode == 6'b000000 && bus.funct == 6'b001000: dec_cls = C_JR;
            bus.opcode == 6'b000000 && bus.funct == 6'b000000: dec_cls = C_NOP;
            bus.opcode == 6'b001101: dec_cls = C_ORI;
            bus.opcode == 6'b100011: dec_cls = C_LW;
            bus.opcode == 6'b101011: dec_cls = C_SW;
            bus.opcode == 6'b000100: dec_cls = C_BEQ;
            bus.opcode == 6'b001111: dec_cls = C_LUI;
            bus.opcode == 6'b000011: dec_cls = C_JAL;
            default:                 dec_cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st   <= S_FETCH;
            wcnt <= 4'd0;
            cls  <= C_NOP;
            cnt  <= '0;
        end else begin
            st   <= st_nxt;
            wcnt <= (st == S_FETCH && !fetch_done) ? wcnt + 4'd1 : 4'd0;
            if (st == S_DECODE) cls <= dec_cls;
            if (retire) cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        st_nxt  = st;
        pc_we   = 1'b0;
        pc_sel  = 2'd0;
        ir_we   = 1'b0;
        reg_we  = 1'b0;
        reg_dst = 2'd0;
        wd_sel  = 2'd0;
        alu_src = 1'b0;
        ext_op  = 1'b0;
        alu_op  = 2'd0;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        retire  = 1'b0;
        illegal = 1'b0;
        case (st)
            S_FETCH: begin
                if (fetch_done) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    st_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                st_nxt = S_EXEC;
                case (dec_cls)
                    C_NOP: begin
                        retire = 1'b1;
                        st_nxt = S_FETCH;
                    end
                    C_ILL: begin
                        retire  = 1'b1;
                        illegal = 1'b1;
                        st_nxt  = S_FETCH;
                    end
                    C_JAL: begin
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        wd_sel  = 2'd2;
                        pc_we   = 1'b1;
                        pc_sel  = 2'd2;
                        retire  = 1'b1;
                        st_nxt  = S_FETCH;
                    end
                    C_JR: begin
                        pc_we  = 1'b1;
                        pc_sel = 2'd3;
                        retire = 1'b1;
                        st_nxt = S_FETCH;
                    end
                    default: ;
                endcase
            end
            S_EXEC, S_MEM, S_WB: begin
                // ALU controls stay stable from EXEC through MEM/WB
                case (cls)
                    C_SUBU: alu_op = 2'd1;
                    C_ORI: begin
                        alu_src = 1'b1;
                        alu_op  = 2'd2;
                    end
                    C_LUI:  alu_src = 1'b1;
                    C_LW, C_SW: begin
                        alu_src = 1'b1;
                        ext_op  = 1'b1;
                    end
                    C_BEQ: begin
                        alu_op = 2'd1;
                        ext_op = 1'b1;
                    end
                    default: ;
                endcase
                if (st == S_EXEC) begin
                    st_nxt = (cls == C_LW || cls == C_SW) ? S_MEM : S_WB;
                    if (cls == C_BEQ) begin
                        pc_sel = 2'd1;
                        pc_we  = bus.zero;
                        retire = 1'b1;
                        st_nxt = S_FETCH;
                    end
                end else if (st == S_MEM) begin
                    mem_re = (cls == C_LW);
                    mem_we = (cls == C_SW);
                    if (bus.mem_ready) begin
                        retire = (cls == C_SW);
                        st_nxt = (cls == C_LW) ? S_WB : S_FETCH;
                    end
                end else begin
                    reg_we = 1'b1;
                    retire = 1'b1;
                    st_nxt = S_FETCH;
                    case (cls)
                        C_ADDU, C_SUBU: reg_dst = 2'd1;
                        C_LUI:          wd_sel  = 2'd3;
                        C_LW:           wd_sel  = 2'd1;
                        default: ;
                    endcase
                end
            end
            default: st_nxt = S_FETCH;
        endcase
    end

    // reset forces FETCH, whose enables must not leak out while reset is held
    assign bus.pc_we     = pc_we & ~reset;
    assign bus.ir_we     = ir_we & ~reset;
    assign bus.reg_we    = reg_we & ~reset;
    assign bus.mem_re    = mem_re & ~reset;
    assign bus.mem_we    = mem_we & ~reset;
    assign bus.retire    = retire & ~reset;
    assign bus.illegal   = illegal & ~reset;
    assign bus.pc_sel    = pc_sel;
    assign bus.reg_dst   = reg_dst;
    assign bus.wd_sel    = wd_sel;
    assign bus.alu_src   = alu_src;
    assign bus.ext_op    = ext_op;
    assign bus.alu_op    = alu_op;
    assign bus.state     = st;
    assign bus.instr_cnt = cnt;
endmodule
